set_assoc_cache: RTL and testbench
==================================

Name: set_assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
- Sits between the CPU memory stage and the line-granular data memory; the data memory is attached through an external line port.
- Adds features the direct-mapped cache lacks:
  - configurable sets and ways
  - victim selection
  - registered request latching
  - hit and miss performance counters

Parameters:
- LINE_SIZE, 16: line size in bytes; power of 2, at least 4.
- NUM_SETS, 16: number of sets; power of 2, at least 2.
- NUM_WAYS, 2: associativity; power of 2, at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- is_input_valid  in  1  CPU request valid
- mem_rw  in  1  1 = write, 0 = read
- addr  in  32  byte address; bits [1:0] are ignored
- din  in  32  write data
- is_ready  out  1  cache can accept a request
- is_output_valid  out  1  one-cycle response pulse
- is_hit  out  1  qualified by is_output_valid; 1 = first lookup hit
- dout  out  32  read data; qualified by is_output_valid
- mem_is_input_valid  out  1  memory request valid
- mem_read  out  1  line read request
- mem_write  out  1  line write request
- mem_addr  out  32  line-aligned address
- mem_din  out  LINE_SIZE*8  writeback line
- mem_ready  in  1  memory accepts the request at this edge
- mem_is_output_valid  in  1  read line valid (one-cycle pulse)
- mem_dout  in  LINE_SIZE*8  fill line
- hit_count  out  32  saturating hit counter
- miss_count  out  32  saturating miss counter

Behaviour:
- Address split:
  - OFF = log2(LINE_SIZE), IDX = log2(NUM_SETS).
  - index = addr[OFF+IDX-1:OFF]; tag = addr[31:OFF+IDX]; word = addr[OFF-1:2].
- Reset state:
  - State is IDLE; all valid, dirty and tag bits are cleared; counters are 0.
  - LRU age of way w in every set is w.
  - Outputs: is_ready=1; is_output_valid, is_hit and all mem_* controls are 0.
- States: IDLE, COMPARE, WRITEBACK, FILL_REQ, FILL_WAIT.
- IDLE:
  - is_ready=1.
  - When is_input_valid is high, latch addr, din and mem_rw, clear miss_flag, and go to COMPARE.
- COMPARE (uses latched request; is_ready=0):
  - Hit (valid and tag match in some way):
    - is_output_valid=1, is_hit=!miss_flag.
    - dout = selected word (pre-write value on writes).
    - Write: update the word and set dirty.
    - Update LRU; if !miss_flag, increment hit_count. Go to IDLE.
  - Miss:
    - Increment miss_count; set miss_flag.
    - Victim is the lowest-index invalid way, otherwise the way with age NUM_WAYS-1.
    - Go to WRITEBACK if the victim is valid and dirty, else FILL_REQ.
- WRITEBACK:
  - mem_is_input_valid=1, mem_write=1.
  - mem_addr = {victim tag, index, OFF zeros}; mem_din = victim line.
  - All held stable until an edge with mem_ready=1, then go to FILL_REQ.
- FILL_REQ:
  - mem_is_input_valid=1, mem_read=1.
  - mem_addr = {tag, index, OFF zeros}.
  - Held until mem_ready=1, then go to FILL_WAIT.
- FILL_WAIT:
  - On mem_is_output_valid, install mem_dout into the victim way with valid=1, dirty=0 and the new tag.
  - Go to COMPARE; this second compare always hits.
- Timing:
  - Hit: request accepted at edge N, response valid in cycle N+1.
  - Miss: response follows fill completion plus one cycle.
- LRU update: the accessed way's age becomes 0; ways with a smaller age than its old age increment by 1; other ways are unchanged.
- Counters saturate at 32'hFFFF_FFFF.
- Boundary conditions:
  - is_input_valid outside IDLE is ignored.
  - mem_is_output_valid outside FILL_WAIT is ignored.
  - mem_ready outside WRITEBACK and FILL_REQ is ignored.
  - Reset in any state returns to IDLE next edge with the full reset state.
  - A pending memory response after reset is discarded.
  - NUM_WAYS=1 degenerates to a direct-mapped cache; the LRU logic is constant.

Decomposition:
- Package cache_pkg holds:
  - state enum
  - OFF, IDX, TAG_W and AGE_W = max(1, log2(NUM_WAYS)) helpers
  - memory request encoding constants
- Sub-module cache_lru, combinational, one instance per lookup. It is given:
  - the ages of the indexed set
  - valid bits
  - the accessed way
- It outputs the victim way and the next ages.

Test Plan:
Configuration: LINE_SIZE=16, NUM_SETS=4, NUM_WAYS=2; set 0 holds 0x000, 0x040, 0x080. Memory model preloaded with word = address ^ 0xA5A5A5A5.
1. Read 0x000 after reset -> one mem read at 0x000; response with is_hit=0 and dout=0xA5A5A5A5. Repeat read -> response in cycle after accept, is_hit=1, no mem traffic; hit_count=1, miss_count=1.
2. Write 0xDEADBEEF to 0x044, then read 0x044 -> second access is_hit=1, dout=0xDEADBEEF; no mem_write issued.
3. Read 0x000, 0x040, 0x000, then 0x080 -> 0x080 evicts the 0x040 line with no writeback (clean). Read 0x000 then hits; read 0x040 then misses.
4. Write 0xCAFEF00D to 0x040, read 0x000, read 0x080 -> mem_write at 0x040 with mem_din[31:0]=0xCAFEF00D, followed by mem_read at 0x080.
5. Hold mem_ready low for 5 cycles during WRITEBACK -> mem_addr, mem_din and mem_is_input_valid stay stable; is_ready=0; toggling is_input_valid has no effect.
6. Assert reset during FILL_WAIT, then pulse mem_is_output_valid -> cache in IDLE with is_ready=1 and counters 0; next read of 0x000 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  // Memory request encoding: {mem_write, mem_read}
  localparam logic [1:0] MEM_REQ_NONE  = 2'b00;
  localparam logic [1:0] MEM_REQ_READ  = 2'b01;
  localparam logic [1:0] MEM_REQ_WRITE = 2'b10;

  function automatic int off_w(input int line_size);
    return $clog2(line_size);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int line_size, input int num_sets);
    return 32 - $clog2(line_size) - $clog2(num_sets);
  endfunction

  function automatic int age_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU request/response, line-memory port and performance counters of the cache.
interface set_assoc_cache_if #(parameter int LINE_SIZE = 16);
  logic                   is_input_valid;
  logic                   mem_rw;
  logic [31:0]            addr;
  logic [31:0]            din;
  logic                   is_ready;
  logic                   is_output_valid;
  logic                   is_hit;
  logic [31:0]            dout;
  logic                   mem_is_input_valid;
  logic                   mem_read;
  logic                   mem_write;
  logic [31:0]            mem_addr;
  logic [LINE_SIZE*8-1:0] mem_din;
  logic                   mem_ready;
  logic                   mem_is_output_valid;
  logic [LINE_SIZE*8-1:0] mem_dout;
  logic [31:0]            hit_count;
  logic [31:0]            miss_count;

  modport master (
    output is_input_valid, mem_rw, addr, din, mem_ready, mem_is_output_valid, mem_dout,
    input  is_ready, is_output_valid, is_hit, dout, mem_is_input_valid, mem_read,
           mem_write, mem_addr, mem_din, hit_count, miss_count
  );

  modport slave (
    input  is_input_valid, mem_rw, addr, din, mem_ready, mem_is_output_valid, mem_dout,
    output is_ready, is_output_valid, is_hit, dout, mem_is_input_valid, mem_read,
           mem_write, mem_addr, mem_din, hit_count, miss_count
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU victim selection and age update for one set (age 0 = most recent).
module cache_lru
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int AGE_W    = age_w(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AGE_W-1:0] ages_i,
  input  logic [NUM_WAYS-1:0]            valid_i,
  input  logic [AGE_W-1:0]               way_i,
  output logic [AGE_W-1:0]               victim_o,
  output logic [NUM_WAYS-1:0][AGE_W-1:0] ages_o
);

  logic [AGE_W-1:0] old_age;

  always_comb begin
    old_age  = ages_i[way_i];
    ages_o   = ages_i;
    victim_o = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages_i[w] == AGE_W'(NUM_WAYS - 1)) victim_o = AGE_W'(w);
    end
    // An empty way always wins over the oldest one; the lowest index is taken.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = AGE_W'(w);
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (AGE_W'(w) == way_i)       ages_o[w] = '0;
      else if (ages_i[w] < old_age) ages_o[w] = ages_i[w] + 1'b1;
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// state     | meaning
// IDLE      | ready for a CPU request
// COMPARE   | tag lookup on the latched request; respond on hit
// WRITEBACK | dirty victim line offered to memory
// FILL_REQ  | line read request offered to memory
// FILL_WAIT | waiting for the fill line
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2
) (
  input logic         clk,
  input logic         reset,
  set_assoc_cache_if.slave bus
);

  localparam int OFF    = off_w(LINE_SIZE);
  localparam int IDX    = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(LINE_SIZE, NUM_SETS);
  localparam int AGE_W  = age_w(NUM_WAYS);
  localparam int LINE_W = LINE_SIZE * 8;
  localparam int WORDS  = LINE_SIZE / 4;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                         state_q, state_d;
  logic [31:2]                    addr_q;
  logic [31:0]                    din_q;
  logic                           rw_q, miss_q;
  logic [AGE_W-1:0]               victim_q;
  logic [31:0]                    hit_cnt_q, miss_cnt_q;
  logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]            dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0][AGE_W-1:0] age_q   [NUM_SETS];
  logic [TAG_W-1:0]               tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]              data_q  [NUM_SETS][NUM_WAYS];

  logic [IDX-1:0]                 index;
  logic [TAG_W-1:0]               tag;
  logic [WORD_W-1:0]              word;
  logic                           hit;
  logic [AGE_W-1:0]               hit_way, lru_victim;
  logic [NUM_WAYS-1:0][AGE_W-1:0] lru_ages;
  logic [LINE_W-1:0]              sel_line;
  logic                           ready_c, out_valid_c;
  logic [1:0]                     mem_req_c;
  logic [31:0]                    mem_addr_c;
  logic [LINE_W-1:0]              mem_din_c;

  assign index = addr_q[OFF+IDX-1:OFF];
  assign tag   = addr_q[31:OFF+IDX];

  if (WORDS > 1) begin : g_word
    assign word = addr_q[OFF-1:2];
  end else begin : g_word_single
    assign word = '0;
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[index][w] && (tag_q[index][w] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  assign sel_line = data_q[index][hit_way];

  cache_lru #(.NUM_WAYS(NUM_WAYS), .AGE_W(AGE_W)) u_lru (
    .ages_i  (age_q[index]),
    .valid_i (valid_q[index]),
    .way_i   (hit_way),
    .victim_o(lru_victim),
    .ages_o  (lru_ages)
  );

  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    out_valid_c = 1'b0;
    mem_req_c   = MEM_REQ_NONE;
    mem_addr_c  = '0;
    mem_din_c   = '0;
    unique case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.is_input_valid) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          out_valid_c = 1'b1;
          state_d     = IDLE;
        end else if (valid_q[index][lru_victim] && dirty_q[index][lru_victim]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL_REQ;
        end
      end
      WRITEBACK: begin
        mem_req_c  = MEM_REQ_WRITE;
        mem_addr_c = {tag_q[index][victim_q], index, {OFF{1'b0}}};
        mem_din_c  = data_q[index][victim_q];
        if (bus.mem_ready) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        mem_req_c  = MEM_REQ_READ;
        mem_addr_c = {tag, index, {OFF{1'b0}}};
        if (bus.mem_ready) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (bus.mem_is_output_valid) state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.is_ready           = ready_c;
  assign bus.is_output_valid    = out_valid_c;
  assign bus.is_hit             = out_valid_c & ~miss_q;
  assign bus.dout               = sel_line[{word, 5'd0} +: 32];
  assign bus.mem_is_input_valid = (mem_req_c != MEM_REQ_NONE);
  assign bus.mem_read           = (mem_req_c == MEM_REQ_READ);
  assign bus.mem_write          = (mem_req_c == MEM_REQ_WRITE);
  assign bus.mem_addr           = mem_addr_c;
  assign bus.mem_din            = mem_din_c;
  assign bus.hit_count          = hit_cnt_q;
  assign bus.miss_count         = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      din_q      <= '0;
      rw_q       <= 1'b0;
      miss_q     <= 1'b0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.is_input_valid) begin
        addr_q <= bus.addr[31:2];
        din_q  <= bus.din;
        rw_q   <= bus.mem_rw;
        miss_q <= 1'b0;
      end
      if (state_q == COMPARE) begin
        if (hit) begin
          age_q[index] <= lru_ages;
          if (rw_q) dirty_q[index][hit_way] <= 1'b1;
          if (!miss_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          miss_q   <= 1'b1;
          victim_q <= lru_victim;
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
      if (state_q == FILL_WAIT && bus.mem_is_output_valid) begin
        valid_q[index][victim_q] <= 1'b1;
        dirty_q[index][victim_q] <= 1'b0;
        tag_q[index][victim_q]   <= tag;
      end
    end
  end

  // Line storage needs no reset: contents are only visible behind a valid bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == COMPARE && hit && rw_q)
        data_q[index][hit_way][{word, 5'd0} +: 32] <= din_q;
      if (state_q == FILL_WAIT && bus.mem_is_output_valid)
        data_q[index][victim_q] <= bus.mem_dout;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed scenarios plus random traffic against an LRU-queue model.
module tb_set_assoc_cache;
  localparam int LINE_SIZE = 16;
  localparam int NUM_SETS  = 4;
  localparam int NUM_WAYS  = 2;

  typedef struct {
    logic [31:0]  base;
    bit           dirty;
    logic [127:0] data;
  } line_t;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  addr;
    logic [127:0] data;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.LINE_SIZE(LINE_SIZE)) bus ();

  set_assoc_cache #(.LINE_SIZE(LINE_SIZE), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory environment
  logic [127:0] dut_mem [logic [31:0]];
  req_t         req_log[$];
  bit           ready_en   = 1'b1;
  bit           rand_ready = 1'b0;
  bit           auto_resp  = 1'b1;
  int           pulse_req  = 0;

  // reference model: per set, resident lines ordered most-recent first
  line_t        sets_q [NUM_SETS][$];
  logic [127:0] ref_mem [logic [31:0]];
  logic [31:0]  m_hit, m_miss;
  bit           exp_hit;
  logic [31:0]  exp_dout;
  req_t         exp_reqs[$];

  bit           last_hit;
  logic [31:0]  last_dout;
  int           last_lat;
  int           log_base;

  function automatic logic [127:0] init_line(input logic [31:0] base);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = (base + 32'(w * 4)) ^ 32'hA5A5_A5A5;
    return l;
  endfunction

  initial begin : responder
    int           resp_cnt;
    int           pulse_seen;
    logic [31:0]  resp_addr;
    resp_cnt   = 0;
    pulse_seen = 0;
    resp_addr  = '0;
    bus.mem_ready           = 1'b0;
    bus.mem_is_output_valid = 1'b0;
    bus.mem_dout            = '0;
    forever begin
      @(negedge clk);
      bus.mem_is_output_valid = 1'b0;
      if (pulse_req != pulse_seen) begin
        pulse_seen = pulse_req;
        bus.mem_is_output_valid = 1'b1;
        bus.mem_dout = {4{32'h1234_5678}};
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.mem_is_output_valid = 1'b1;
          bus.mem_dout = dut_mem.exists(resp_addr) ? dut_mem[resp_addr] : init_line(resp_addr);
        end
      end
      bus.mem_ready = ready_en && (!rand_ready || ($urandom_range(0, 1) == 1));
      if (bus.mem_ready && bus.mem_is_input_valid && !reset) begin
        req_log.push_back('{bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_din});
        if (bus.mem_write) begin
          dut_mem[bus.mem_addr] = bus.mem_din;
        end else if (auto_resp) begin
          resp_addr = bus.mem_addr;
          resp_cnt  = 3;
        end
      end
    end
  end

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) sets_q[s].delete();
    m_hit  = '0;
    m_miss = '0;
  endtask

  task automatic model_access(input bit rw, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] base;
    int s, w, found;
    line_t ln, v;
    base  = a & 32'hFFFF_FFF0;
    s     = int'(a[5:4]);
    w     = int'(a[3:2]);
    found = -1;
    exp_reqs.delete();
    for (int i = 0; i < sets_q[s].size(); i++) if (sets_q[s][i].base == base) found = i;
    if (found >= 0) begin
      exp_hit = 1'b1;
      ln = sets_q[s][found];
      sets_q[s].delete(found);
      if (m_hit != 32'hFFFF_FFFF) m_hit++;
    end else begin
      exp_hit = 1'b0;
      if (m_miss != 32'hFFFF_FFFF) m_miss++;
      if (sets_q[s].size() == NUM_WAYS) begin
        v = sets_q[s].pop_back();
        if (v.dirty) begin
          ref_mem[v.base] = v.data;
          exp_reqs.push_back('{1'b1, 1'b0, v.base, v.data});
        end
      end
      ln.base  = base;
      ln.dirty = 1'b0;
      ln.data  = ref_mem.exists(base) ? ref_mem[base] : init_line(base);
      exp_reqs.push_back('{1'b0, 1'b1, base, 128'h0});
    end
    exp_dout = ln.data[w*32 +: 32];
    if (rw) begin
      ln.data[w*32 +: 32] = d;
      ln.dirty = 1'b1;
    end
    sets_q[s].push_front(ln);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.is_input_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_access(input bit rw, input logic [31:0] a, input logic [31:0] d, input int stall);
    bit got;
    logic [31:0]  cap_addr;
    logic [127:0] cap_din;
    model_access(rw, a, d);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (bus.is_ready === 1'b1) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_before_req addr=%h: is_ready=%b expected 1", a, bus.is_ready);
    end
    log_base = req_log.size();
    bus.is_input_valid = 1'b1;
    bus.mem_rw = rw;
    bus.addr   = a;
    bus.din    = d;
    @(negedge clk);
    bus.is_input_valid = 1'b0;
    bus.addr   = $urandom;
    bus.din    = $urandom;
    bus.mem_rw = 1'($urandom_range(0, 1));
    if (stall > 0) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        if (bus.mem_is_input_valid === 1'b1 && bus.mem_write === 1'b1) got = 1'b1;
        else @(negedge clk);
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL wb_start: mem_write=%b expected 1 within 20 cycles", bus.mem_write);
      end
      cap_addr = bus.mem_addr;
      cap_din  = bus.mem_din;
      n_tests++;
      if (exp_reqs.size() < 2 || cap_addr !== exp_reqs[0].addr) begin
        n_fail++;
        $display("FAIL wb_addr: got %h expected %h", cap_addr, (exp_reqs.size() > 0) ? exp_reqs[0].addr : 32'h0);
      end
      for (int i = 0; i < stall; i++) begin
        bus.is_input_valid = i[0];
        bus.addr   = $urandom;
        bus.mem_rw = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.mem_addr !== cap_addr || bus.mem_din !== cap_din || bus.mem_is_input_valid !== 1'b1 ||
            bus.mem_write !== 1'b1) begin
          n_fail++;
          $display("FAIL wb_hold cycle %0d: addr=%h valid=%b write=%b expected addr=%h valid=1 write=1",
                   i, bus.mem_addr, bus.mem_is_input_valid, bus.mem_write, cap_addr);
        end
        n_tests++;
        if (bus.is_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL wb_not_ready cycle %0d: is_ready=%b expected 0", i, bus.is_ready);
        end
      end
      bus.is_input_valid = 1'b0;
      ready_en = 1'b1;
    end
    got = 1'b0;
    last_lat = 0;
    for (int c = 1; c <= 300 && !got; c++) begin
      if (bus.is_output_valid === 1'b1) begin
        got = 1'b1;
        last_lat = c;
      end else begin
        @(negedge clk);
      end
    end
    last_hit  = bus.is_hit;
    last_dout = bus.dout;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL response_timeout addr=%h: no is_output_valid expected within 300 cycles", a);
    end
    n_tests++;
    if (bus.is_hit !== exp_hit) begin
      n_fail++;
      $display("FAIL is_hit addr=%h: got %b expected %b", a, bus.is_hit, exp_hit);
    end
    n_tests++;
    if (bus.dout !== exp_dout) begin
      n_fail++;
      $display("FAIL dout addr=%h: got %h expected %h", a, bus.dout, exp_dout);
    end
    if (exp_hit) begin
      n_tests++;
      if (last_lat !== 1) begin
        n_fail++;
        $display("FAIL hit_latency addr=%h: got %0d cycles expected 1", a, last_lat);
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.is_output_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_pulse addr=%h: is_output_valid=%b expected 0 after response", a, bus.is_output_valid);
    end
    n_tests++;
    if (bus.hit_count !== m_hit || bus.miss_count !== m_miss) begin
      n_fail++;
      $display("FAIL counters addr=%h: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
               a, bus.hit_count, bus.miss_count, m_hit, m_miss);
    end
    n_tests++;
    if (req_log.size() - log_base !== exp_reqs.size()) begin
      n_fail++;
      $display("FAIL mem_req_count addr=%h: got %0d expected %0d", a, req_log.size() - log_base, exp_reqs.size());
    end else begin
      for (int i = 0; i < exp_reqs.size(); i++) begin
        n_tests++;
        if (req_log[log_base+i].wr !== exp_reqs[i].wr || req_log[log_base+i].rd !== exp_reqs[i].rd ||
            req_log[log_base+i].addr !== exp_reqs[i].addr ||
            (exp_reqs[i].wr && req_log[log_base+i].data !== exp_reqs[i].data)) begin
          n_fail++;
          $display("FAIL mem_req[%0d] addr=%h: got wr=%b rd=%b at %h expected wr=%b rd=%b at %h",
                   i, a, req_log[log_base+i].wr, req_log[log_base+i].rd, req_log[log_base+i].addr,
                   exp_reqs[i].wr, exp_reqs[i].rd, exp_reqs[i].addr);
        end
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.is_ready !== 1'b1) begin n_fail++; $display("FAIL reset_is_ready: got %b expected 1", bus.is_ready); end
    n_tests++;
    if (bus.is_output_valid !== 1'b0 || bus.is_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: got valid=%b hit=%b expected 0 0", bus.is_output_valid, bus.is_hit);
    end
    n_tests++;
    if (bus.mem_is_input_valid !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem_ctrl: got valid=%b rd=%b wr=%b expected 0 0 0",
               bus.mem_is_input_valid, bus.mem_read, bus.mem_write);
    end
    n_tests++;
    if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_read_miss_hit();
    do_access(1'b0, 32'h000, 32'h0, 0);
    n_tests++;
    if (last_hit !== 1'b0 || last_dout !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL first_read: got hit=%b dout=%h expected hit=0 dout=a5a5a5a5", last_hit, last_dout);
    end
    n_tests++;
    if (req_log.size() - log_base !== 1 || req_log[log_base].addr !== 32'h000) begin
      n_fail++;
      $display("FAIL first_read_mem: got %0d requests expected one read at 0", req_log.size() - log_base);
    end
    do_access(1'b0, 32'h000, 32'h0, 0);
    n_tests++;
    if (last_hit !== 1'b1 || last_lat !== 1 || bus.hit_count !== 32'd1 || bus.miss_count !== 32'd1) begin
      n_fail++;
      $display("FAIL repeat_read: got hit=%b lat=%0d cnt=%0d/%0d expected 1 1 1/1",
               last_hit, last_lat, bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_write_allocate();
    do_access(1'b1, 32'h044, 32'hDEAD_BEEF, 0);
    do_access(1'b0, 32'h044, 32'h0, 0);
    n_tests++;
    if (last_hit !== 1'b1 || last_dout !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_then_read: got hit=%b dout=%h expected 1 deadbeef", last_hit, last_dout);
    end
  endtask

  task automatic test_lru_clean_evict();
    apply_reset();
    do_access(1'b0, 32'h000, 32'h0, 0);
    do_access(1'b0, 32'h040, 32'h0, 0);
    do_access(1'b0, 32'h000, 32'h0, 0);
    do_access(1'b0, 32'h080, 32'h0, 0);
    do_access(1'b0, 32'h000, 32'h0, 0);
    n_tests++;
    if (last_hit !== 1'b1) begin n_fail++; $display("FAIL lru_keep_000: got hit=%b expected 1", last_hit); end
    do_access(1'b0, 32'h040, 32'h0, 0);
    n_tests++;
    if (last_hit !== 1'b0) begin n_fail++; $display("FAIL lru_evicted_040: got hit=%b expected 0", last_hit); end
  endtask

  task automatic test_dirty_evict();
    apply_reset();
    do_access(1'b1, 32'h040, 32'hCAFE_F00D, 0);
    do_access(1'b0, 32'h000, 32'h0, 0);
    do_access(1'b0, 32'h080, 32'h0, 0);
    n_tests++;
    if (req_log.size() - log_base !== 2 || req_log[log_base].wr !== 1'b1 || req_log[log_base].addr !== 32'h040 ||
        req_log[log_base].data[31:0] !== 32'hCAFE_F00D || req_log[log_base+1].addr !== 32'h080) begin
      n_fail++;
      $display("FAIL dirty_evict: got %0d requests expected write 040 (cafef00d) then read 080",
               req_log.size() - log_base);
    end
  endtask

  task automatic test_wb_stall();
    apply_reset();
    do_access(1'b1, 32'h050, 32'h1357_9BDF, 0);
    do_access(1'b0, 32'h010, 32'h0, 0);
    ready_en = 1'b0;
    do_access(1'b0, 32'h090, 32'h0, 5);
    do_access(1'b0, 32'h050, 32'h0, 0);
    n_tests++;
    if (last_dout !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL wb_refetch: got %h expected 13579bdf", last_dout);
    end
  endtask

  task automatic test_reset_in_fill();
    int n0;
    bit got;
    apply_reset();
    auto_resp = 1'b0;
    n0 = req_log.size();
    @(negedge clk);
    bus.is_input_valid = 1'b1;
    bus.mem_rw = 1'b0;
    bus.addr   = 32'h000;
    @(negedge clk);
    bus.is_input_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_log.size() > n0) got = 1'b1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL fill_req_seen: no read request expected within 20 cycles"); end
    @(negedge clk);
    @(negedge clk);
    apply_reset();
    @(posedge clk);
    pulse_req++;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.is_ready !== 1'b1 || bus.is_output_valid !== 1'b0 || bus.mem_is_input_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_fill: got ready=%b ovalid=%b mvalid=%b expected 1 0 0",
               bus.is_ready, bus.is_output_valid, bus.mem_is_input_valid);
    end
    n_tests++;
    if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_in_fill_cnt: got %0d/%0d expected 0/0", bus.hit_count, bus.miss_count);
    end
    auto_resp = 1'b1;
    do_access(1'b0, 32'h000, 32'h0, 0);
    n_tests++;
    if (last_hit !== 1'b0) begin n_fail++; $display("FAIL after_reset_miss: got hit=%b expected 0", last_hit); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      do_access(1'($urandom_range(0, 1)), a, $urandom, 0);
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    bus.is_input_valid = 1'b0;
    bus.mem_rw = 1'b0;
    bus.addr   = '0;
    bus.din    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_read_miss_hit();
    test_write_allocate();
    test_lru_clean_evict();
    test_dirty_evict();
    test_wb_stall();
    test_reset_in_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected completion");
    $fatal(1);
  end

endmodule
